// File: rtl/pwm_fader.sv
// pwm_fader
//   Produces the 8-bit duty value VAL for a downstream PWM modulator.
//   It ramps VAL toward a target at a programmable tick rate and step size.
//   MODE selects a one-shot fade to TARGET or continuous breathing between
//   0 and TARGET. START/STOP control the engine. BUSY is high while a fade
//   is running, and DONE pulses for one cycle when a one-shot fade completes.
//
// Ports
//   CLK     in   1  clock
//   RST_N   in   1  asynchronous reset, active-low
//   START   in   1  start request, sampled only while idle
//   STOP    in   1  abort, honoured in any state, wins over START
//   MODE    in   1  0 = one-shot fade, 1 = breathing 0<->TARGET
//   TARGET  in   8  fade target / breathing peak, latched on accepted START
//   STEP    in   4  increment per tick, latched on START, 0 behaves as 1
//   VAL     out  8  registered duty value
//   BUSY    out  1  registered, high while not idle
//   DONE    out  1  registered one-cycle pulse at one-shot completion

module pwm_fader #(
  parameter int CLK_FREQ   = 12000000,
  parameter int STEP_HZ    = 1000,
  parameter int HOLD_STEPS = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       MODE,
  input  logic [7:0] TARGET,
  input  logic [3:0] STEP,
  output logic [7:0] VAL,
  output logic       BUSY,
  output logic       DONE
);

  localparam int TP = CLK_FREQ / STEP_HZ;
  localparam int PW = $clog2(TP);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [PW-1:0] TP_LAST   = PW'(TP - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_HOLD_HI,
    S_HOLD_LO
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    val_q, val_d;
  logic          done_q, done_d;
  logic          busy_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    tgt_q, tgt_d;
  logic [3:0]    stp_q, stp_d;
  logic          mode_q, mode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_acc;
  logic          tick;

  logic [8:0]        up_sum;
  logic signed [9:0] dn_diff;
  logic [7:0]        dn_floor;

  assign tick = (presc_q == TP_LAST);

  // The arithmetic runs one bit wider than VAL (unsigned for the ramp up,
  // signed for the ramp down), so clamping against the target or the floor
  // happens before any 8-bit wrap can occur.
  assign up_sum   = {1'b0, val_q} + {5'b0, stp_q};
  assign dn_diff  = $signed({2'b00, val_q}) - $signed({6'b0, stp_q});
  assign dn_floor = mode_q ? 8'd0 : tgt_q;

  // Next-state logic. STOP is checked first, so it overrides both START and
  // any tick update. When STOP is asserted, VAL keeps its current value.
  // Breathing with a zero peak is latched as one-shot mode, so a later
  // ramp-down uses tgt (0) as its floor.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    done_d    = 1'b0;
    tgt_d     = tgt_q;
    stp_d     = stp_q;
    mode_d    = mode_q;
    hold_d    = hold_q;
    start_acc = 1'b0;
    if (STOP) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            start_acc = 1'b1;
            tgt_d     = TARGET;
            stp_d     = (STEP == 4'd0) ? 4'd1 : STEP;
            mode_d    = MODE && (TARGET != 8'd0);
            if (TARGET > val_q) begin
              state_d = S_UP;
            end else if (TARGET < val_q) begin
              state_d = S_DOWN;
            end else if (mode_d) begin
              state_d = S_HOLD_HI;
              hold_d  = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, tgt_q}) begin
              val_d = tgt_q;
              if (mode_q) begin
                state_d = S_HOLD_HI;
                hold_d  = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              val_d = up_sum[7:0];
            end
          end
        end
        S_DOWN: begin
          if (tick) begin
            if (dn_diff <= $signed({2'b00, dn_floor})) begin
              val_d = dn_floor;
              if (mode_q) begin
                state_d = S_HOLD_LO;
                hold_d  = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              val_d = dn_diff[7:0];
            end
          end
        end
        S_HOLD_HI: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) state_d = S_DOWN;
            else                     hold_d  = hold_q + HW'(1);
          end
        end
        S_HOLD_LO: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) state_d = S_UP;
            else                     hold_d  = hold_q + HW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers. The prescaler restarts on an accepted START,
  // so the first step lands exactly one tick period after the START edge.
  // BUSY is registered from the next state, so it drops on the same edge
  // that raises DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      tgt_q   <= '0;
      stp_q   <= '0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      if (start_acc || tick) presc_q <= '0;
      else                   presc_q <= presc_q + PW'(1);
    end
  end

  assign VAL  = val_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader
//   Self-checking bench for pwm_fader with a tick period of 10 cycles and
//   2 hold ticks. Expected per-tick results go into a scoreboard queue when
//   a fade is started. They are popped and compared as the DUT steps.

module tb_pwm_fader;

  localparam int CLK_FREQ   = 1000;
  localparam int STEP_HZ    = 100;
  localparam int HOLD_STEPS = 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       mode   = 1'b0;
  logic [7:0] target = '0;
  logic [3:0] step   = '0;
  logic [7:0] val;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] val;
    logic       done;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [7:0] target;
    logic [3:0] step;
    logic [7:0] final_val;
    bit         poke;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[4];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_val = '0;
  logic [7:0] prev_val  = '0;

  pwm_fader #(
    .CLK_FREQ  (CLK_FREQ),
    .STEP_HZ   (STEP_HZ),
    .HOLD_STEPS(HOLD_STEPS)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .START (start),
    .STOP  (stop),
    .MODE  (mode),
    .TARGET(target),
    .STEP  (step),
    .VAL   (val),
    .BUSY  (busy),
    .DONE  (done)
  );

  // 10-time-unit clock period
  always #5 clk = ~clk;

  // Compares one value, then updates the comparison and failure counts.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference for one ramp step: move toward the target by the step size
  // (a step of 0 counts as 1), and never go past the target.
  function automatic logic [7:0] refStep(input logic [7:0] v, input logic [7:0] t, input logic [3:0] s);
    int st;
    int nv;
    st = (s == 4'd0) ? 1 : int'(s);
    if (t > v) begin
      nv = int'(v) + st;
      if (nv > int'(t)) nv = int'(t);
    end else begin
      nv = int'(v) - st;
      if (nv < int'(t)) nv = int'(t);
    end
    return 8'(nv);
  endfunction

  // Presents a START request for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] t, input logic [3:0] s, input logic m);
    start  = 1'b1;
    target = t;
    step   = s;
    mode   = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Pushes the expected value after every tick of a one-shot fade.
  task automatic pushFade(input logic [7:0] t, input logic [3:0] s);
    exp_t e;
    prev_val = model_val;
    for (int i = 0; i < 300 && model_val != t; i++) begin
      model_val = refStep(model_val, t, s);
      e.val  = model_val;
      e.done = (model_val == t);
      e.busy = (model_val != t);
      sb.push_back(e);
    end
  endtask

  // For each scoreboard entry: VAL must hold steady during the cycles before
  // the tick edge and must match the entry right after that edge. The
  // optional poke sends a START with a new TARGET/STEP in the middle of the
  // fade, and the DUT must ignore it.
  task automatic checkTicks(input bit poke);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < 9; c++) begin
        @(posedge clk);
        #1;
        if (poke && c == 3) begin
          start  = 1'b1;
          target = 8'd0;
          step   = 4'd1;
        end
        if (c == 4) start = 1'b0;
      end
      @(negedge clk);
      checkOutput("val_stable", val, prev_val);
      checkOutput("busy_mid", {7'b0, busy}, 8'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("val_tick", val, e.val);
      checkOutput("done_tick", {7'b0, done}, {7'b0, e.done});
      checkOutput("busy_tick", {7'b0, busy}, {7'b0, e.busy});
      prev_val = e.val;
    end
  endtask

  // Main sequence: reset state, one-shot vectors from the table, then
  // hand-written corner cases (equal target, async reset, breathing, STOP).
  initial begin
    exp_t e;
    logic [7:0] breath[9];

    vecs[0] = '{target: 8'd40,  step: 4'd16, final_val: 8'd40,  poke: 1'b1};
    vecs[1] = '{target: 8'd37,  step: 4'd0,  final_val: 8'd37,  poke: 1'b0};
    vecs[2] = '{target: 8'd250, step: 4'd15, final_val: 8'd250, poke: 1'b0};
    vecs[3] = '{target: 8'd255, step: 4'd15, final_val: 8'd255, poke: 1'b1};

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_val", val, 8'd0);
    checkOutput("reset_busy", {7'b0, busy}, 8'd0);
    checkOutput("reset_done", {7'b0, done}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_val = 8'd0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].target, vecs[i].step, 1'b0);
      pushFade(vecs[i].target, vecs[i].step);
      checkTicks(vecs[i].poke);
      checkOutput("final_val", val, vecs[i].final_val);
      @(negedge clk);
      checkOutput("done_width", {7'b0, done}, 8'd0);
    end

    // START with a target equal to VAL: stay idle and pulse DONE once.
    applyStimulus(8'd255, 4'd3, 1'b0);
    @(negedge clk);
    checkOutput("eq_done", {7'b0, done}, 8'd1);
    checkOutput("eq_busy", {7'b0, busy}, 8'd0);
    checkOutput("eq_val", val, 8'd255);
    @(negedge clk);
    checkOutput("eq_done_width", {7'b0, done}, 8'd0);

    // Asynchronous reset in the middle of a fade clears outputs without a clock edge.
    applyStimulus(8'd0, 4'd8, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_val", val, 8'd247);
    checkOutput("pre_reset_busy", {7'b0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_val", val, 8'd0);
    checkOutput("async_busy", {7'b0, busy}, 8'd0);
    checkOutput("async_done", {7'b0, done}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_val = 8'd0;

    // Breathing 0<->8 with step 4, holding 2 ticks at each extreme.
    breath = '{8'd4, 8'd8, 8'd8, 8'd8, 8'd4, 8'd0, 8'd0, 8'd0, 8'd4};
    applyStimulus(8'd8, 4'd4, 1'b1);
    prev_val = 8'd0;
    for (int i = 0; i < 9; i++) begin
      e.val  = breath[i];
      e.done = 1'b0;
      e.busy = 1'b1;
      sb.push_back(e);
    end
    checkTicks(1'b0);

    // STOP on the same cycle as a tick in UP: the update is discarded.
    repeat (9) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    checkOutput("stop_val", val, 8'd4);
    checkOutput("stop_busy", {7'b0, busy}, 8'd0);
    checkOutput("stop_done", {7'b0, done}, 8'd0);

    // START and STOP together: STOP wins, and nothing moves afterwards.
    start  = 1'b1;
    stop   = 1'b1;
    target = 8'd100;
    step   = 4'd5;
    mode   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    checkOutput("ss_busy", {7'b0, busy}, 8'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("ss_val", val, 8'd4);
    checkOutput("ss_busy_late", {7'b0, busy}, 8'd0);
    checkOutput("ss_done", {7'b0, done}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
